mem_line_loader: RTL

//  Converts a stream of (byte address, 32-bit word) records into full-width, byte-enabled

---
 rtl/mem_line_loader_pkg.sv | 35 +++
 rtl/mem_line_pack.sv | 21 ++
 rtl/mem_line_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_line_loader_pkg.sv
// Shared types and helpers for mem_line_loader: FSM state encoding, line geometry
// functions and the word-insert helper used by the line packer.
package mem_line_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FLUSH_LOAD = 2'd3
  } state_t;

  localparam int MAX_LINE_WIDTH = 256;

  // Byte-offset bits within one line.
  function automatic int calc_lb(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int calc_words(input int line_width);
    return line_width / 32;
  endfunction

  // Replaces 32-bit word idx of a line (held at the widest supported size).
  function automatic logic [MAX_LINE_WIDTH-1:0] insert_word(
    input int                        idx,
    input logic [MAX_LINE_WIDTH-1:0] line,
    input logic [31:0]               word
  );
    logic [MAX_LINE_WIDTH-1:0] w_res;
    w_res = line;
    w_res[idx*32 +: 32] = word;
    return w_res;
  endfunction

endpackage

// File: rtl/mem_line_pack.sv
// Combinational merge of one 32-bit word and its four byte enables into a line buffer.
module mem_line_pack
  import mem_line_loader_pkg::*;
#(
  parameter int LINE_WIDTH = 128
) (
  input  logic [LINE_WIDTH-1:0]   i_line,
  input  logic [LINE_WIDTH/8-1:0] i_be,
  input  logic [2:0]              i_idx,
  input  logic [31:0]             i_word,
  output logic [LINE_WIDTH-1:0]   o_line,
  output logic [LINE_WIDTH/8-1:0] o_be
);

  localparam int BE_W = LINE_WIDTH / 8;
  localparam logic [BE_W-1:0] BE_NIB = BE_W'(4'hF);

  assign o_line = LINE_WIDTH'(insert_word(int'(i_idx), MAX_LINE_WIDTH'(i_line), i_word));
  assign o_be   = i_be | (BE_NIB << {i_idx, 2'b00});

endmodule

// File: rtl/mem_line_loader.sv
// Coalesces (byte address, word) records into byte-enabled line writes.
// Optional statistics counters are built when MEM_LINE_LOADER_STATS_EN is defined.
//
// state         | meaning
// ST_IDLE       | buffer empty, no write outstanding
// ST_FILL       | buffer holds a partial line, accepting records
// ST_FLUSH      | line write presented, waiting for i_wr_ready
// ST_FLUSH_LOAD | line write presented, a different-line record is held pending
module mem_line_loader
  import mem_line_loader_pkg::*;
#(
  parameter int                    LINE_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_LO     = '0,
  parameter logic [ADDR_WIDTH-1:0] WIN_HI     = '1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_rec_valid,
  output logic                                        o_rec_ready,
  input  logic [ADDR_WIDTH-1:0]                       i_rec_addr,
  input  logic [31:0]                                 i_rec_data,
  input  logic                                        i_flush,
  output logic                                        o_wr_valid,
  input  logic                                        i_wr_ready,
  output logic [ADDR_WIDTH-calc_lb(LINE_WIDTH)-1:0]   o_wr_addr,
  output logic [LINE_WIDTH-1:0]                       o_wr_data,
  output logic [LINE_WIDTH/8-1:0]                     o_wr_be,
  output logic                                        o_idle,
  output logic                                        o_err
`ifdef MEM_LINE_LOADER_STATS_EN
  ,
  output logic [31:0]                                 o_rec_count,
  output logic [15:0]                                 o_drop_count,
  output logic [31:0]                                 o_line_count
`endif
);

  localparam int LB   = calc_lb(LINE_WIDTH);
  localparam int BE_W = LINE_WIDTH / 8;
  localparam int LA_W = ADDR_WIDTH - LB;
  localparam logic [2:0] IDX_MASK = 3'(calc_words(LINE_WIDTH) - 1);

  function automatic logic addr_le(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    return a <= b;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [LA_W-1:0]       r_line_addr, r_pend_addr;
  logic [LINE_WIDTH-1:0] r_data;
  logic [BE_W-1:0]       r_be;
  logic [2:0]            r_pend_idx;
  logic [31:0]           r_pend_data;
  logic                  r_flush_pend;
  logic                  r_err;

  logic                  w_acc, w_ok, w_good, w_drop, w_same_line, w_wr_fire;
  logic [LA_W-1:0]       w_rec_line, w_load_addr;
  logic [2:0]            w_rec_idx, w_pk_idx;
  logic [LINE_WIDTH-1:0] w_pk_line_in, w_pk_line;
  logic [BE_W-1:0]       w_pk_be_in, w_pk_be;
  logic [31:0]           w_pk_word;
  logic                  w_pk_full;
  logic                  w_buf_load, w_pend_store;

  assign o_rec_ready = !i_rst && (r_state == ST_IDLE || r_state == ST_FILL);
  assign o_wr_valid  = (r_state == ST_FLUSH) || (r_state == ST_FLUSH_LOAD);
  assign o_wr_addr   = r_line_addr;
  assign o_wr_data   = r_data;
  assign o_wr_be     = r_be;
  assign o_idle      = (r_state == ST_IDLE);
  assign o_err       = r_err;

  assign w_acc       = i_rec_valid && o_rec_ready;
  assign w_ok        = (i_rec_addr[1:0] == 2'b00) && addr_le(WIN_LO, i_rec_addr)
                       && addr_le(i_rec_addr, WIN_HI);
  assign w_good      = w_acc && w_ok;
  assign w_drop      = w_acc && !w_ok;
  assign w_rec_line  = i_rec_addr[ADDR_WIDTH-1:LB];
  assign w_rec_idx   = i_rec_addr[4:2] & IDX_MASK;
  assign w_same_line = (w_rec_line == r_line_addr);
  assign w_wr_fire   = o_wr_valid && i_wr_ready;

  // Only FILL merges into the live buffer; IDLE and FLUSH_LOAD start a fresh line.
  assign w_pk_line_in = (r_state == ST_FILL) ? r_data : '0;
  assign w_pk_be_in   = (r_state == ST_FILL) ? r_be : '0;
  assign w_pk_idx     = (r_state == ST_FLUSH_LOAD) ? r_pend_idx : w_rec_idx;
  assign w_pk_word    = (r_state == ST_FLUSH_LOAD) ? r_pend_data : i_rec_data;
  assign w_load_addr  = (r_state == ST_FLUSH_LOAD) ? r_pend_addr : w_rec_line;
  assign w_pk_full    = &w_pk_be;

  mem_line_pack #(.LINE_WIDTH(LINE_WIDTH)) u_pack (
    .i_line (w_pk_line_in),
    .i_be   (w_pk_be_in),
    .i_idx  (w_pk_idx),
    .i_word (w_pk_word),
    .o_line (w_pk_line),
    .o_be   (w_pk_be)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_load   = 1'b0;
    w_pend_store = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_good) begin
          w_buf_load  = 1'b1;
          w_state_nxt = w_pk_full ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_good && w_same_line) begin
          w_buf_load = 1'b1;
          if (w_pk_full || i_flush) w_state_nxt = ST_FLUSH;
        end else if (w_good) begin
          w_pend_store = 1'b1;
          w_state_nxt  = ST_FLUSH_LOAD;
        end else if (i_flush) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_wr_ready) w_state_nxt = ST_IDLE;
      end
      ST_FLUSH_LOAD: begin
        if (i_wr_ready) begin
          w_buf_load  = 1'b1;
          w_state_nxt = (r_flush_pend || w_pk_full) ? ST_FLUSH : ST_FILL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data       <= '0;
      r_be         <= '0;
      r_line_addr  <= '0;
      r_pend_addr  <= '0;
      r_pend_idx   <= '0;
      r_pend_data  <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_buf_load) begin
        r_data      <= w_pk_line;
        r_be        <= w_pk_be;
        r_line_addr <= w_load_addr;
      end
      if (w_pend_store) begin
        r_pend_addr  <= w_rec_line;
        r_pend_idx   <= w_rec_idx;
        r_pend_data  <= i_rec_data;
        r_flush_pend <= i_flush;
      end else if (r_state == ST_FLUSH_LOAD && i_wr_ready) begin
        r_flush_pend <= 1'b0;
      end
      if (w_drop) r_err <= 1'b1;
    end
  end

`ifdef MEM_LINE_LOADER_STATS_EN
  logic [31:0] r_rec_count;
  logic [15:0] r_drop_count;
  logic [31:0] r_line_count;

  // All counters hold at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rec_count  <= '0;
      r_drop_count <= '0;
      r_line_count <= '0;
    end else begin
      if (w_acc && r_rec_count != '1)      r_rec_count  <= r_rec_count + 32'd1;
      if (w_drop && r_drop_count != '1)    r_drop_count <= r_drop_count + 16'd1;
      if (w_wr_fire && r_line_count != '1) r_line_count <= r_line_count + 32'd1;
    end
  end

  assign o_rec_count  = r_rec_count;
  assign o_drop_count = r_drop_count;
  assign o_line_count = r_line_count;
`endif

endmodule
